// File: rtl/booth_mult_param_if.sv
// Operand/result bundle for booth_mult_param: start request and operands in, busy/done and product out.
interface booth_mult_param_if #(
    parameter int WIDTH = 32
);
    logic             iGo;
    logic             iSigned;
    logic [WIDTH-1:0] iMer;
    logic [WIDTH-1:0] iMand;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oAns_hi;
    logic [WIDTH-1:0] oAns_lo;

    modport master (
        output iGo, iSigned, iMer, iMand,
        input  oBusy, oDone, oAns_hi, oAns_lo
    );

    modport slave (
        input  iGo, iSigned, iMer, iMand,
        output oBusy, oDone, oAns_hi, oAns_lo
    );
endinterface

// File: rtl/booth_mult_param.sv
// Iterative radix-4 Booth multiplier, signed or unsigned per operation, 2*WIDTH-bit product.
// Result WIDTH/2 (signed) or WIDTH/2+1 (unsigned) cycles after accept; iGo is ignored unless idle.
module booth_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic              iClk,
    input  logic              iReset_b,
    booth_mult_param_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH/2 + 2);
    localparam int XW    = WIDTH + 2;
    localparam int PW    = 2*XW + 1;
    localparam logic [CNT_W-1:0] CNT_SIGNED   = CNT_W'(WIDTH/2 - 1);
    localparam logic [CNT_W-1:0] CNT_UNSIGNED = CNT_W'(WIDTH/2);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t           r_state;
    logic [XW-1:0]    r_acc;
    logic [XW-1:0]    r_mer;
    logic             r_guard;
    logic [XW-1:0]    r_mand;
    logic             r_signed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_ans_hi;
    logic [WIDTH-1:0] r_ans_lo;

    logic [2:0]         w_sel;
    logic [XW-1:0]      w_addend;
    logic [XW-1:0]      w_sum;
    logic [PW-1:0]      w_next;
    logic [2*WIDTH-1:0] w_ans;
    logic [XW-1:0]      w_mer_x;
    logic [XW-1:0]      w_mand_x;

    assign w_mer_x  = {{2{bus.iSigned & bus.iMer[WIDTH-1]}},  bus.iMer};
    assign w_mand_x = {{2{bus.iSigned & bus.iMand[WIDTH-1]}}, bus.iMand};

    always_comb begin
        w_sel    = {r_mer[1:0], r_guard};
        w_addend = '0;
        case (w_sel)
            3'b001, 3'b010: w_addend = r_mand;
            3'b011:         w_addend = r_mand << 1;
            3'b100:         w_addend = -(r_mand << 1);
            3'b101, 3'b110: w_addend = -r_mand;
            default:        w_addend = '0;
        endcase
        w_sum  = r_acc + w_addend;
        w_next = $signed({w_sum, r_mer, r_guard}) >>> 2;
        // Signed runs stop two bits short of consuming the extended multiplier,
        // so the product sits one digit higher in the register than for unsigned.
        w_ans  = r_signed ? w_next[2*WIDTH+2:3] : w_next[2*WIDTH:1];
    end

    always_ff @(posedge iClk or negedge iReset_b) begin
        if (!iReset_b) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mer    <= '0;
            r_guard  <= 1'b0;
            r_mand   <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ans_hi <= '0;
            r_ans_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.iGo) begin
                        r_acc    <= '0;
                        r_mer    <= w_mer_x;
                        r_guard  <= 1'b0;
                        r_mand   <= w_mand_x;
                        r_signed <= bus.iSigned;
                        r_cnt    <= bus.iSigned ? CNT_SIGNED : CNT_UNSIGNED;
                        r_busy   <= 1'b1;
                        r_state  <= S_ITER;
                    end
                end
                S_ITER: begin
                    {r_acc, r_mer, r_guard} <= w_next;
                    if (r_cnt == '0) begin
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_ans_hi <= w_ans[2*WIDTH-1:WIDTH];
                        r_ans_lo <= w_ans[WIDTH-1:0];
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oBusy   = r_busy;
    assign bus.oDone   = r_done;
    assign bus.oAns_hi = r_ans_hi;
    assign bus.oAns_lo = r_ans_lo;
endmodule

// File: tb/tb_booth_mult_param.sv
module tb_booth_mult_param;
    logic iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic [1:0]  rst_b;
    logic        go   [2];
    logic        sg   [2];
    logic [63:0] mer  [2];
    logic [63:0] mand [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic [63:0] ans_w  [2];
    int          wid    [2] = '{32, 8};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    booth_mult_param_if #(.WIDTH(32)) if32 ();
    booth_mult_param_if #(.WIDTH(8))  if8 ();

    assign if32.iGo    = go[0];
    assign if32.iSigned = sg[0];
    assign if32.iMer   = mer[0][31:0];
    assign if32.iMand  = mand[0][31:0];
    assign if8.iGo     = go[1];
    assign if8.iSigned = sg[1];
    assign if8.iMer    = mer[1][7:0];
    assign if8.iMand   = mand[1][7:0];

    assign busy_w[0] = if32.oBusy;
    assign done_w[0] = if32.oDone;
    assign ans_w[0]  = {if32.oAns_hi, if32.oAns_lo};
    assign busy_w[1] = if8.oBusy;
    assign done_w[1] = if8.oDone;
    assign ans_w[1]  = {48'd0, if8.oAns_hi, if8.oAns_lo};

    booth_mult_param #(.WIDTH(32)) dut32 (.iClk(iClk), .iReset_b(rst_b[0]), .bus(if32));
    booth_mult_param #(.WIDTH(8))  dut8  (.iClk(iClk), .iReset_b(rst_b[1]), .bus(if8));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact product by plain integer arithmetic on sign/zero-extended operands.
    function automatic logic [63:0] ref_mul(input int w, input logic s, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m, x, y, p;
        m = (64'd1 << w) - 64'd1;
        x = a & m;
        y = b & m;
        if (s && x[w-1]) x = x | ~m;
        if (s && y[w-1]) y = y | ~m;
        p = x * y;
        if (w < 32) p = p & ((64'd1 << (2*w)) - 64'd1);
        return p;
    endfunction

    // Reference model: one pending operation with a due cycle, plus the held result.
    logic        m_pend [2] = '{1'b0, 1'b0};
    int          m_due  [2] = '{0, 0};
    logic [63:0] m_prod [2] = '{64'd0, 64'd0};
    logic [63:0] m_ans  [2] = '{64'd0, 64'd0};

    task automatic check_inst(input int k, input logic rb, input logic g, input logic s,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic bz, input logic dn, input logic [63:0] an);
        logic exp_busy, exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (!rb) begin
            m_pend[k] = 1'b0;
            m_ans[k]  = 64'd0;
        end else begin
            exp_done = m_pend[k] && (cyc == m_due[k]);
            exp_busy = m_pend[k] && (cyc <  m_due[k]);
            if (exp_done) m_ans[k] = m_prod[k];
        end
        chk($sformatf("busy_w%0d", wid[k]), 64'(bz), 64'(exp_busy));
        chk($sformatf("done_w%0d", wid[k]), 64'(dn), 64'(exp_done));
        chk($sformatf("ans_w%0d", wid[k]),  an, m_ans[k]);
        if (rb) begin
            if (exp_done) begin
                m_pend[k] = 1'b0;
            end else if (!m_pend[k] && g) begin
                m_pend[k] = 1'b1;
                m_due[k]  = cyc + 1 + (s ? wid[k]/2 : wid[k]/2 + 1);
                m_prod[k] = ref_mul(wid[k], s, a, b);
            end
        end
    endtask

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        check_inst(0, rst_b[0], if32.iGo, if32.iSigned, 64'(if32.iMer), 64'(if32.iMand),
                   busy_w[0], done_w[0], ans_w[0]);
        check_inst(1, rst_b[1], if8.iGo, if8.iSigned, 64'(if8.iMer), 64'(if8.iMand),
                   busy_w[1], done_w[1], ans_w[1]);
    end

    function automatic logic [63:0] pick(input int k);
        logic [63:0] c [6];
        logic [63:0] m;
        m = (64'd1 << wid[k]) - 64'd1;
        c = '{64'd0, 64'd1, 64'd2, m, m >> 1, (m >> 1) + 64'd1};
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
        return {$urandom, $urandom} & m;
    endfunction

    // Issue one operation from idle; returns the product and edges from accept to oDone.
    task automatic run(input int k, input logic s, input logic [63:0] a, input logic [63:0] b,
                       input bit noise, output logic [63:0] res, output int lat);
        sg[k] = s; mer[k] = a; mand[k] = b; go[k] = 1'b1;
        @(posedge iClk); #1;
        go[k] = 1'b0;
        lat = 0;
        while (!done_w[k] && lat < 40) begin
            if (noise) begin
                go[k]   = 1'($urandom_range(0, 1));
                sg[k]   = 1'($urandom_range(0, 1));
                mer[k]  = {$urandom, $urandom};
                mand[k] = {$urandom, $urandom};
            end
            @(posedge iClk); #1;
            lat++;
        end
        go[k] = 1'b0;
        chk($sformatf("done_seen_w%0d", wid[k]), 64'(done_w[k]), 64'd1);
        res = ans_w[k];
        @(posedge iClk); #1;
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        int          ndone;
        logic [63:0] cv [8];

        rst_b = 2'b00;
        for (int k = 0; k < 2; k++) begin
            go[k] = 1'b0; sg[k] = 1'b0; mer[k] = 64'd0; mand[k] = 64'd0;
        end
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_busy32", 64'(busy_w[0]), 64'd0);
        chk("rst_done32", 64'(done_w[0]), 64'd0);
        chk("rst_ans32",  ans_w[0], 64'd0);
        rst_b = 2'b11;
        @(posedge iClk); #1;

        run(0, 1'b1, 64'hFFFFFFFF, 64'h2, 1'b0, res, lat);
        chk("s_m1x2", res, 64'hFFFFFFFF_FFFFFFFE);
        chk("s_lat32", 64'(lat), 64'd16);
        run(0, 1'b0, 64'hFFFFFFFF, 64'h2, 1'b0, res, lat);
        chk("u_ffx2", res, 64'h00000001_FFFFFFFE);
        chk("u_lat32", 64'(lat), 64'd17);
        run(0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, res, lat);
        chk("u_ffxff", res, 64'hFFFFFFFE_00000001);
        run(0, 1'b1, 64'h80000000, 64'h80000000, 1'b1, res, lat);
        chk("s_minxmin", res, 64'h40000000_00000000);
        run(0, 1'b1, 64'h80000000, 64'h1, 1'b1, res, lat);
        chk("s_minx1", res, 64'hFFFFFFFF_80000000);

        // Operand change and iGo while busy must not disturb the running operation.
        sg[0] = 1'b0; mer[0] = 64'd7; mand[0] = 64'd9; go[0] = 1'b1;
        @(posedge iClk); #1;
        go[0] = 1'b0;
        ndone = 0;
        res = 64'd0;
        for (int e = 1; e <= 19; e++) begin
            @(posedge iClk); #1;
            if (e == 2) mer[0] = 64'd3;
            if (e == 4) begin go[0] = 1'b1; mand[0] = 64'd3; end
            if (e == 5) go[0] = 1'b0;
            if (done_w[0]) begin ndone++; res = ans_w[0]; end
        end
        chk("ign_res", res, 64'h3F);
        chk("ign_ndone", 64'(ndone), 64'd1);
        run(0, 1'b0, 64'd3, 64'd3, 1'b0, res, lat);
        chk("u_3x3", res, 64'd9);

        // Reset mid-operation aborts with no oDone and clears the held result.
        sg[0] = 1'b1; mer[0] = 64'd5; mand[0] = 64'd6; go[0] = 1'b1;
        @(posedge iClk); #1;
        go[0] = 1'b0;
        ndone = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge iClk); #1;
            if (e == 8) rst_b[0] = 1'b0;
            if (e == 9) rst_b[0] = 1'b1;
            if (done_w[0]) ndone++;
        end
        chk("abort_ndone", 64'(ndone), 64'd0);
        chk("abort_busy",  64'(busy_w[0]), 64'd0);
        chk("abort_ans",   ans_w[0], 64'd0);
        run(0, 1'b1, 64'hFFFFFFFD, 64'd5, 1'b0, res, lat);
        chk("s_m3x5", res, 64'hFFFFFFFF_FFFFFFF1);

        run(1, 1'b1, 64'h80, 64'h80, 1'b0, res, lat);
        chk("s8_minxmin", res, 64'h4000);
        chk("s_lat8", 64'(lat), 64'd4);
        run(1, 1'b0, 64'hFF, 64'hFF, 1'b0, res, lat);
        chk("u8_ffxff", res, 64'hFE01);
        chk("u_lat8", 64'(lat), 64'd5);
        run(1, 1'b1, 64'hFF, 64'h02, 1'b0, res, lat);
        chk("s8_m1x2", res, 64'hFFFE);

        for (int i = 0; i < 200; i++) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            run(0, s, pick(0), pick(0), 1'b1, res, lat);
            chk("rnd_lat32", 64'(lat), s ? 64'd16 : 64'd17);
        end

        cv = '{64'h00, 64'h01, 64'h02, 64'h7F, 64'h80, 64'h81, 64'hFE, 64'hFF};
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++) begin
                    run(1, 1'(m), cv[i], cv[j], 1'b0, res, lat);
                    chk("grid_lat8", 64'(lat), (m == 1) ? 64'd4 : 64'd5);
                end
        for (int i = 0; i < 2500; i++) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            run(1, s, pick(1), pick(1), 1'b1, res, lat);
            chk("rnd_lat8", 64'(lat), s ? 64'd4 : 64'd5);
        end

        repeat (2) @(posedge iClk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
